// File: rtl/cpu_bus_if_wb_pkg.sv
// Shared encodings for the CPU-side bus interface: FSM states, bus direction,
// active-low strobe levels and the default slave-index field location.
package cpu_bus_if_wb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } bus_state_e;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int SLV_IDX_MSB = 29;
    localparam int SLV_IDX_LSB = 27;

endpackage

// File: rtl/cpu_bus_if_wb_if.sv
// CPU / SPM / shared-bus signal bundle. The slave modport is the interface
// block's view; the master modport is the pipeline-plus-bus environment's view.
interface cpu_bus_if_wb_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              stall;
    logic              flush;
    logic              busy;
    logic [ADDR_W-1:0] addr;
    logic              as_n;
    logic              rw;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] spm_addr;
    logic              spm_as_n;
    logic              spm_rw;
    logic [DATA_W-1:0] spm_wr_data;
    logic [DATA_W-1:0] spm_rd_data;
    logic              bus_req_n;
    logic              bus_grnt_n;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as_n;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_n;
    logic              bus_err;
    logic              wbuf_empty;

    modport slave (
        input  stall, flush, addr, as_n, rw, wr_data, spm_rd_data,
               bus_grnt_n, bus_rd_data, bus_rdy_n,
        output busy, rd_data, spm_addr, spm_as_n, spm_rw, spm_wr_data,
               bus_req_n, bus_addr, bus_as_n, bus_rw, bus_wr_data,
               bus_err, wbuf_empty
    );

    modport master (
        output stall, flush, addr, as_n, rw, wr_data, spm_rd_data,
               bus_grnt_n, bus_rd_data, bus_rdy_n,
        input  busy, rd_data, spm_addr, spm_as_n, spm_rw, spm_wr_data,
               bus_req_n, bus_addr, bus_as_n, bus_rw, bus_wr_data,
               bus_err, wbuf_empty
    );

endinterface

// File: rtl/cpu_bus_if_wb_wbuf.sv
// Posted-write FIFO of {addr,data}. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate count.
module cpu_bus_if_wb_wbuf #(
    parameter int WIDTH = 62,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/cpu_bus_if_wb.sv
// CPU-side bus interface: SPM bypass, posted-write buffer drained ahead of
// reads, and a per-access timeout that aborts with a one-cycle bus_err.
module cpu_bus_if_wb
    import cpu_bus_if_wb_pkg::*;
#(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int IDX_MSB    = SLV_IDX_MSB,
    parameter int IDX_LSB    = SLV_IDX_LSB,
    parameter int SPM_IDX    = 1,
    parameter int WBUF_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input logic            clk,
    input logic            reset,
    cpu_bus_if_wb_if.slave bif
);
    localparam int IDX_W = IDX_MSB - IDX_LSB + 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] SPM_SEL  = IDX_W'(SPM_IDX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

    bus_state_e        state_q, state_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
    logic              bus_rw_q, bus_rw_d;
    logic              bus_req_n_q, bus_req_n_d;
    logic              bus_as_n_q, bus_as_n_d;
    logic              bus_err_q, bus_err_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic                     cpu_vld, is_spm, spm_acc, wr_req, rd_req;
    logic                     rdy, grnt, timeout_hit, xfer_end, rd_ret;
    logic                     push, pop, wb_full, wb_empty;
    logic [ADDR_W+DATA_W-1:0] wb_head;
    logic                     busy_o, spm_as_n_o;
    logic [DATA_W-1:0]        rd_data_o;

    assign cpu_vld = (bif.as_n == ENABLE_) && !bif.flush;
    assign is_spm  = (bif.addr[IDX_MSB:IDX_LSB] == SPM_SEL);
    assign spm_acc = cpu_vld && is_spm;
    assign wr_req  = cpu_vld && !is_spm && (bif.rw == WRITE);
    assign rd_req  = cpu_vld && !is_spm && (bif.rw == READ);

    assign rdy         = (bif.bus_rdy_n == ENABLE_);
    assign grnt        = (bif.bus_grnt_n == ENABLE_);
    assign timeout_hit = (state_q == ACCESS) && !rdy && (cnt_q == CNT_LAST);
    assign xfer_end    = (state_q == ACCESS) && (rdy || timeout_hit);
    assign rd_ret      = xfer_end && (bus_rw_q == READ);
    // A timed-out write is dropped so the buffer cannot wedge on a dead slave.
    assign pop         = xfer_end && (bus_rw_q == WRITE);
    assign push        = wr_req && !wb_full && !bif.stall;

    cpu_bus_if_wb_wbuf #(
        .WIDTH(ADDR_W + DATA_W),
        .DEPTH(WBUF_DEPTH)
    ) u_wbuf (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .pop_i  (pop),
        .din_i  ({bif.addr, bif.wr_data}),
        .head_o (wb_head),
        .full_o (wb_full),
        .empty_o(wb_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!wb_empty || rd_req) state_d = REQ;
            REQ:     if (grnt) state_d = ACCESS;
            ACCESS:  if (xfer_end)
                         state_d = (bus_rw_q == READ && bif.stall) ? STALL : IDLE;
            STALL:   if (!bif.stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        bus_rw_d      = bus_rw_q;
        bus_req_n_d   = bus_req_n_q;
        bus_as_n_d    = DISABLE_;
        bus_err_d     = 1'b0;
        rd_buf_d      = rd_buf_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                // Buffered writes go first so a read never overtakes them.
                if (!wb_empty) begin
                    {bus_addr_d, bus_wr_data_d} = wb_head;
                    bus_rw_d    = WRITE;
                    bus_req_n_d = ENABLE_;
                end else if (rd_req) begin
                    bus_addr_d  = bif.addr;
                    bus_rw_d    = READ;
                    bus_req_n_d = ENABLE_;
                end
            end
            REQ: begin
                if (grnt) begin
                    bus_as_n_d = ENABLE_;
                    cnt_d      = '0;
                end
            end
            ACCESS: begin
                if (xfer_end) begin
                    bus_req_n_d   = DISABLE_;
                    bus_addr_d    = '0;
                    bus_wr_data_d = '0;
                    bus_rw_d      = READ;
                    if (bus_rw_q == READ) rd_buf_d = rdy ? bif.bus_rd_data : '0;
                    if (!rdy) begin
                        bus_err_d = 1'b1;
                        cnt_d     = CNT_SAT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_o     = 1'b0;
        rd_data_o  = '0;
        spm_as_n_o = DISABLE_;
        if (spm_acc) begin
            if (!bif.stall) spm_as_n_o = ENABLE_;
            if (bif.rw == READ) rd_data_o = bif.spm_rd_data;
        end else if (state_q == STALL) begin
            rd_data_o = rd_buf_q;
            busy_o    = wr_req && wb_full;
        end else if (rd_ret) begin
            rd_data_o = rdy ? bif.bus_rd_data : '0;
        end else if (rd_req || (wr_req && wb_full)) begin
            busy_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            bus_rw_q      <= READ;
            bus_req_n_q   <= DISABLE_;
            bus_as_n_q    <= DISABLE_;
            bus_err_q     <= 1'b0;
            rd_buf_q      <= '0;
            cnt_q         <= '0;
        end else begin
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            bus_rw_q      <= bus_rw_d;
            bus_req_n_q   <= bus_req_n_d;
            bus_as_n_q    <= bus_as_n_d;
            bus_err_q     <= bus_err_d;
            rd_buf_q      <= rd_buf_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bif.busy        = busy_o;
    assign bif.rd_data     = rd_data_o;
    assign bif.spm_addr    = bif.addr;
    assign bif.spm_as_n    = spm_as_n_o;
    assign bif.spm_rw      = bif.rw;
    assign bif.spm_wr_data = bif.wr_data;
    assign bif.bus_req_n   = bus_req_n_q;
    assign bif.bus_addr    = bus_addr_q;
    assign bif.bus_as_n    = bus_as_n_q;
    assign bif.bus_rw      = bus_rw_q;
    assign bif.bus_wr_data = bus_wr_data_q;
    assign bif.bus_err     = bus_err_q;
    assign bif.wbuf_empty  = wb_empty;

endmodule
